// File: rtl/reg_file_sb.sv
// reg_file_sb: two-read / one-write register file with an issue scoreboard.
// Register 0 reads as zero and is never busy. The optional write-to-read
// bypass forwards writeback data and busy status within the same cycle.
// pend_cnt holds the number of busy registers after each clock edge.
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] ruRs1,
  output logic [XLEN-1:0] ruRs2,
  output logic            busy1,
  output logic            busy2,
  input  logic            ruWr,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] dataWR_Ru,
  input  logic            iss,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush,
  output logic [AW:0]     pend_cnt
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_sb;
  logic [AW:0]      r_pend_cnt;

  logic [NREGS-1:0] w_sb_next;
  logic             w_wr_en;
  logic             w_iss_en;
  logic             w_iss_same;
  logic             w_fwd1;
  logic             w_fwd2;

  // Number of set bits in a scoreboard vector.
  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt = cnt + (AW+1)'(v[i]);
    end
    return cnt;
  endfunction

  assign w_wr_en    = ruWr && (rd != '0);
  assign w_iss_en   = iss && (iss_rd != '0);
  assign w_iss_same = w_iss_en && (iss_rd == rd);
  assign w_fwd1     = (BYPASS != 0) && w_wr_en && (rd == rs1);
  assign w_fwd2     = (BYPASS != 0) && w_wr_en && (rd == rs2);

  // Next scoreboard: flush clears first, writeback clears, issue sets last so it wins.
  always_comb begin
    w_sb_next = flush ? '0 : r_sb;
    if (w_wr_en) begin
      w_sb_next[rd] = 1'b0;
    end
    if (w_iss_en) begin
      w_sb_next[iss_rd] = 1'b1;
    end
    w_sb_next[0] = 1'b0;
  end

  // Register array storage; reset clears every entry, writes to register 0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[rd] <= dataWR_Ru;
    end
  end

  // Scoreboard bits and registered popcount; reset overrides issue, writeback and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb       <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_sb       <= w_sb_next;
      r_pend_cnt <= popcount(w_sb_next);
    end
  end

  // Read port 1 with optional same-cycle forwarding of writeback data and busy state.
  always_comb begin
    ruRs1 = '0;
    busy1 = 1'b0;
    if (rs1 != '0) begin
      if (w_fwd1) begin
        ruRs1 = dataWR_Ru;
        busy1 = w_iss_same;
      end else begin
        ruRs1 = r_regs[rs1];
        busy1 = r_sb[rs1];
      end
    end
  end

  // Read port 2, identical to port 1.
  always_comb begin
    ruRs2 = '0;
    busy2 = 1'b0;
    if (rs2 != '0) begin
      if (w_fwd2) begin
        ruRs2 = dataWR_Ru;
        busy2 = w_iss_same;
      end else begin
        ruRs2 = r_regs[rs2];
        busy2 = r_sb[rs2];
      end
    end
  end

  assign pend_cnt = r_pend_cnt;

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb: directed vector table, BYPASS=0 sequence,
// then randomized traffic against an array-based reference model.
module tb_reg_file_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   rs1, rs2, rd, iss_rd;
  logic            ruWr, iss, flush;
  logic [XLEN-1:0] dataWR_Ru;
  logic [XLEN-1:0] ruRs1, ruRs2, nb_ruRs1, nb_ruRs2;
  logic            busy1, busy2, nb_busy1, nb_busy2;
  logic [AW:0]     pend_cnt, nb_pend_cnt;

  int n_cmp = 0;
  int n_err = 0;

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .ruRs1(ruRs1), .ruRs2(ruRs2),
    .busy1(busy1), .busy2(busy2), .ruWr(ruWr), .rd(rd), .dataWR_Ru(dataWR_Ru),
    .iss(iss), .iss_rd(iss_rd), .flush(flush), .pend_cnt(pend_cnt)
  );

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .ruRs1(nb_ruRs1), .ruRs2(nb_ruRs2),
    .busy1(nb_busy1), .busy2(nb_busy2), .ruWr(ruWr), .rd(rd), .dataWR_Ru(dataWR_Ru),
    .iss(iss), .iss_rd(iss_rd), .flush(flush), .pend_cnt(nb_pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arrays of register values and busy flags.
  logic [XLEN-1:0] m_reg  [NREGS];
  bit              m_busy [NREGS];

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NREGS; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && ruWr && rd == a) return dataWR_Ru;
    return m_reg[a];
  endfunction

  function automatic logic m_bsy(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && ruWr && rd == a) return iss && (iss_rd == rd);
    return m_busy[a];
  endfunction

  task automatic m_edge();
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 0;
      end
    end else begin
      if (ruWr && rd != 0) m_reg[rd] = dataWR_Ru;
      if (flush) for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
      if (ruWr && rd != 0) m_busy[rd] = 0;
      if (iss && iss_rd != 0) m_busy[iss_rd] = 1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic            rst, wr;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] wd;
    logic            iss;
    logic [AW-1:0]   ird;
    logic            flush;
    logic [AW-1:0]   rs1, rs2;
    logic            chk;
    logic [XLEN-1:0] e_r1, e_r2;
    logic            e_b1, e_b2;
    logic [AW:0]     e_pend;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic r, input logic w, input int d, input logic [31:0] wd,
                              input logic is, input int ird, input logic fl, input int a1, input int a2,
                              input logic c, input logic [31:0] er1, input logic [31:0] er2,
                              input logic eb1, input logic eb2, input int ep);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = AW'(d); v.wd = wd; v.iss = is; v.ird = AW'(ird); v.flush = fl;
    v.rs1 = AW'(a1); v.rs2 = AW'(a2); v.chk = c; v.e_r1 = er1; v.e_r2 = er2;
    v.e_b1 = eb1; v.e_b2 = eb2; v.e_pend = (AW+1)'(ep);
    return v;
  endfunction

  task automatic drive(input logic r, input logic w, input logic [AW-1:0] d, input logic [XLEN-1:0] wd,
                       input logic is, input logic [AW-1:0] ird, input logic fl,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rst = r; ruWr = w; rd = d; dataWR_Ru = wd; iss = is; iss_rd = ird; flush = fl; rs1 = a1; rs2 = a2;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NREGS; i++) begin m_reg[i] = '0; m_busy[i] = 0; end

    //          rst wr rd data          iss ird fl rs1 rs2 chk  r1            r2            b1 b2 pend
    tbl[0]  = mk(1, 0, 0, 32'h0,        0, 0,  0, 0,  0,  0, 32'h0,        32'h0,        0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 32'h0,        0, 0,  0, 5,  31, 1, 32'h0,        32'h0,        0, 0, 0);
    tbl[2]  = mk(0, 1, 5, 32'hDEADBEEF, 0, 0,  0, 5,  0,  1, 32'hDEADBEEF, 32'h0,        0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 32'h1,        0, 0,  0, 0,  5,  1, 32'h0,        32'hDEADBEEF, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 32'h0,        1, 3,  0, 3,  7,  1, 32'h0,        32'h0,        0, 0, 1);
    tbl[5]  = mk(0, 0, 0, 32'h0,        1, 7,  0, 3,  7,  1, 32'h0,        32'h0,        1, 0, 2);
    tbl[6]  = mk(0, 1, 3, 32'h33,       0, 0,  0, 3,  7,  1, 32'h33,       32'h0,        0, 1, 1);
    tbl[7]  = mk(0, 0, 0, 32'h0,        1, 4,  0, 3,  4,  1, 32'h33,       32'h0,        0, 0, 2);
    tbl[8]  = mk(0, 1, 4, 32'h44,       1, 4,  0, 4,  7,  1, 32'h44,       32'h0,        1, 1, 2);
    tbl[9]  = mk(0, 0, 0, 32'h0,        0, 0,  0, 4,  0,  1, 32'h44,       32'h0,        1, 0, 2);
    tbl[10] = mk(0, 0, 0, 32'h0,        1, 10, 0, 10, 11, 1, 32'h0,        32'h0,        0, 0, 3);
    tbl[11] = mk(0, 0, 0, 32'h0,        1, 11, 0, 10, 11, 1, 32'h0,        32'h0,        1, 0, 4);
    tbl[12] = mk(0, 0, 0, 32'h0,        1, 12, 0, 12, 4,  1, 32'h0,        32'h44,       0, 1, 5);
    tbl[13] = mk(0, 0, 0, 32'h0,        1, 9,  1, 9,  12, 1, 32'h0,        32'h0,        0, 1, 1);
    tbl[14] = mk(0, 0, 0, 32'h0,        0, 0,  0, 9,  12, 1, 32'h0,        32'h0,        1, 0, 1);
    tbl[15] = mk(0, 0, 0, 32'h0,        1, 1,  0, 1,  2,  1, 32'h0,        32'h0,        0, 0, 2);
    tbl[16] = mk(0, 0, 0, 32'h0,        1, 2,  0, 1,  2,  1, 32'h0,        32'h0,        1, 0, 3);
    tbl[17] = mk(1, 1, 6, 32'h66,       1, 6,  1, 1,  2,  1, 32'h0,        32'h0,        1, 1, 0);
    tbl[18] = mk(0, 0, 0, 32'h0,        0, 0,  0, 6,  5,  1, 32'h0,        32'h0,        0, 0, 0);
    tbl[19] = mk(0, 0, 0, 32'h0,        1, 8,  0, 8,  0,  1, 32'h0,        32'h0,        0, 0, 1);
    tbl[20] = mk(0, 0, 0, 32'h0,        0, 0,  0, 8,  0,  1, 32'h0,        32'h0,        1, 0, 1);

    @(posedge clk); #1;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].wd, tbl[i].iss, tbl[i].ird, tbl[i].flush,
            tbl[i].rs1, tbl[i].rs2);
      #3;
      if (tbl[i].chk) begin
        chk($sformatf("vec%0d_ruRs1", i), 64'(ruRs1), 64'(tbl[i].e_r1));
        chk($sformatf("vec%0d_ruRs2", i), 64'(ruRs2), 64'(tbl[i].e_r2));
        chk($sformatf("vec%0d_busy1", i), 64'(busy1), 64'(tbl[i].e_b1));
        chk($sformatf("vec%0d_busy2", i), 64'(busy2), 64'(tbl[i].e_b2));
      end
      @(posedge clk);
      m_edge();
      #1;
      chk($sformatf("vec%0d_pend_cnt", i), 64'(pend_cnt), 64'(tbl[i].e_pend));
    end

    // Forwarding disabled: write data and busy clear only visible after the edge.
    drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
    #3;
    chk("byp1_same_cycle", 64'(ruRs1), 64'(32'hDEADBEEF));
    chk("byp0_same_cycle", 64'(nb_ruRs1), 64'(32'h0));
    @(posedge clk); m_edge(); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 5, 0);
    #3;
    chk("byp0_next_cycle", 64'(nb_ruRs1), 64'(32'hDEADBEEF));
    @(posedge clk); m_edge(); #1;
    drive(0, 1, 8, 32'h88, 0, 0, 0, 8, 0);
    #3;
    chk("byp1_busy_fwd", 64'(busy1), 64'(1'b0));
    chk("byp0_busy_old", 64'(nb_busy1), 64'(1'b1));
    chk("byp0_data_old", 64'(nb_ruRs1), 64'(32'h0));
    @(posedge clk); m_edge(); #1;
    chk("byp0_pend_after_wr", 64'(nb_pend_cnt), 64'(0));
    drive(0, 0, 0, 0, 0, 0, 0, 8, 0);
    #3;
    chk("byp0_data_after_wr", 64'(nb_ruRs1), 64'(32'h88));
    @(posedge clk); m_edge(); #1;

    // Randomized traffic against the reference model; addresses biased to collide.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic r, w, is, fl;
      logic [AW-1:0] d, ird, a1, a2;
      r   = ($urandom_range(0, 299) == 0);
      fl  = ($urandom_range(0, 59) == 0);
      w   = ($urandom_range(0, 2) == 0);
      is  = ($urandom_range(0, 1) == 0);
      d   = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      ird = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      a1  = ($urandom_range(0, 3) == 0) ? d : AW'($urandom_range(0, 7));
      a2  = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom);
      drive(r, w, d, XLEN'($urandom), is, ird, fl, a1, a2);
      #3;
      chk("rnd_ruRs1",    64'(ruRs1),    64'(m_read(a1, 1)));
      chk("rnd_ruRs2",    64'(ruRs2),    64'(m_read(a2, 1)));
      chk("rnd_busy1",    64'(busy1),    64'(m_bsy(a1, 1)));
      chk("rnd_busy2",    64'(busy2),    64'(m_bsy(a2, 1)));
      chk("rnd_nb_ruRs1", 64'(nb_ruRs1), 64'(m_read(a1, 0)));
      chk("rnd_nb_busy1", 64'(nb_busy1), 64'(m_bsy(a1, 0)));
      @(posedge clk);
      m_edge();
      #1;
      chk("rnd_pend_cnt",    64'(pend_cnt),    64'(m_count()));
      chk("rnd_nb_pend_cnt", 64'(nb_pend_cnt), 64'(m_count()));
    end

    // Register 0 must still read zero on both ports.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("final_reg0_p1", 64'(ruRs1), 64'(0));
    chk("final_reg0_p2", 64'(nb_ruRs2), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning register count; power of two, 2..64; AW = log2(NREGS).
REQ-003 SHALL have parameter BYPASS, default 1, meaning 1 enables same-cycle write-to-read forwarding and 0 disables it.
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports rs1, rs2  input  AW  read addresses.
REQ-007 SHALL have ports ruRs1, ruRs2  output  XLEN  read data.
REQ-008 SHALL have ports busy1, busy2  output  1  scoreboard busy flags for rs1 and rs2.
REQ-009 SHALL have port ruWr  input  1  write enable (writeback).
REQ-010 SHALL have port rd  input  AW  write address.
REQ-011 SHALL have port dataWR_Ru  input  XLEN  write data.
REQ-012 SHALL have port iss  input  1  issue strobe; marks iss_rd as having a pending producer.
REQ-013 SHALL have port iss_rd  input  AW  issued destination address.
REQ-014 SHALL have port flush  input  1  clears every pending busy flag.
REQ-015 SHALL have port pend_cnt  output  AW+1  number of registers currently busy.

Function
REQ-016 SHALL make register 0 read as 0, ignore writes to it, and never mark it busy; iss with iss_rd=0 is a no-op.
REQ-017 SHALL perform reads combinationally: ruRsN = reg[rsN], busyN = sb[rsN].
REQ-018 SHALL, on the rising edge with ruWr=1 and rd!=0, store dataWR_Ru in reg[rd].
REQ-019 SHALL, with BYPASS=1, ruWr=1, rd!=0 and rd==rsN, drive ruRsN = dataWR_Ru and busyN = 0 in the same cycle, unless iss=1 and iss_rd==rd, in which case busyN = 1.
REQ-020 SHALL, with BYPASS=0, present write data on reads one cycle after the write edge.
REQ-021 SHALL set sb[iss_rd] on the edge when iss=1 and iss_rd!=0; setting an already-busy register leaves it busy (single bit, no nesting).
REQ-022 SHALL clear sb[rd] on the edge when ruWr=1 and rd!=0; a write to a non-busy register is legal and leaves it non-busy.
REQ-023 SHALL give the set priority when iss and ruWr target the same nonzero address in one cycle: reg updated, sb ends 1.
REQ-024 SHALL clear all sb bits on the edge when flush=1; a coincident ruWr still writes reg, and a coincident iss sets its bit after the clear (sb ends with only iss_rd set).
REQ-025 SHALL register pend_cnt, equal to the popcount of sb after each edge, in range 0..NREGS-1; increments by at most 1 and decrements by at most 1 per cycle except on flush.
REQ-026 SHALL keep pend_cnt unchanged when iss and ruWr hit the same already-busy register.

Reset
REQ-027 SHALL, on any edge with rst=1, clear all reg to 0, all sb to 0 and pend_cnt to 0, overriding ruWr, iss and flush that cycle.
REQ-028 SHALL make reset mid-operation discard all pending issues with no residual busy flag; the first edge after rst deasserts behaves normally.

Verification
REQ-029 SHALL cover: rst 1 cycle, then read all addresses -> ruRs1/ruRs2 = 0, busy = 0, pend_cnt = 0.
REQ-030 SHALL cover: ruWr=1, rd=5, data 0xDEADBEEF, rs1=5 same cycle -> ruRs1 = 0xDEADBEEF same cycle (BYPASS=1), next cycle (BYPASS=0); write rd=0 data 0x1 -> reg0 reads 0.
REQ-031 SHALL cover: iss rd=3, iss rd=7 on consecutive edges -> pend_cnt 1 then 2, busy for rs=3 -> 1; ruWr rd=3 -> busy 0, pend_cnt 1.
REQ-032 SHALL cover: iss rd=4 and ruWr rd=4 in same cycle with 4 already busy -> reg4 updated, busy 1, pend_cnt unchanged.
REQ-033 SHALL cover: 5 registers busy, flush with iss rd=9 -> pend_cnt = 1, only reg 9 busy; rst with 3 busy -> pend_cnt 0 next cycle.
REQ-034 SHALL cover: random iss/ruWr/flush for 10k cycles vs reference model -> pend_cnt always equals popcount(sb), reg0 always 0.
